// File: rtl/otter_cu_fsm_dcdr_if.sv
// Control bundle between the OTTER control unit (master) and the datapath (slave):
// instruction/branch-compare inputs, plus the enables and mux selects the control unit produces.
interface otter_cu_fsm_dcdr_if;
    logic [31:0] ir;
    logic        br_eq;
    logic        br_lt;
    logic        br_ltu;
    logic        pcWrite;
    logic        regWrite;
    logic        memWE2;
    logic        memRDEN1;
    logic        memRDEN2;
    logic [3:0]  alu_fun;
    logic        alu_srcA;
    logic [1:0]  alu_srcB;
    logic [2:0]  pcSource;
    logic [1:0]  rf_wr_sel;
    logic        illegal_op;

    modport master (
        input  ir, br_eq, br_lt, br_ltu,
        output pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               alu_fun, alu_srcA, alu_srcB, pcSource, rf_wr_sel, illegal_op
    );

    modport slave (
        output ir, br_eq, br_lt, br_ltu,
        input  pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
               alu_fun, alu_srcA, alu_srcB, pcSource, rf_wr_sel, illegal_op
    );
endinterface

// File: rtl/otter_cu_fsm_dcdr.sv
// OTTER RV32I multicycle control unit: INIT/FETCH/EXEC/WRITEBACK sequencer with a
// combinational decoder driving the ALU operand muxes, PC source and memory/regfile enables.
module otter_cu_fsm_dcdr (
    input  logic                CLK,
    input  logic                RST,
    otter_cu_fsm_dcdr_if.master bus
);
    typedef enum logic [1:0] {ST_INIT, ST_FETCH, ST_EXEC, ST_WRITEBACK} state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    state_t     state, next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;
    logic       unused_ir_bits;

    assign opcode         = bus.ir[6:0];
    assign funct3         = bus.ir[14:12];
    assign unused_ir_bits = ^{bus.ir[31], bus.ir[29:15], bus.ir[11:7]};

    // NOTE: sequential state uses non-blocking assignments; RST is in the sensitivity list so it wins without a clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_INIT;
        else     state <= next_state;
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken =  bus.br_eq;
            3'b001:  br_taken = !bus.br_eq;
            3'b100:  br_taken =  bus.br_lt;
            3'b101:  br_taken = !bus.br_lt;
            3'b110:  br_taken =  bus.br_ltu;
            3'b111:  br_taken = !bus.br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        next_state     = state;
        bus.pcWrite    = 1'b0;
        bus.regWrite   = 1'b0;
        bus.memWE2     = 1'b0;
        bus.memRDEN1   = 1'b0;
        bus.memRDEN2   = 1'b0;
        bus.alu_fun    = 4'b0000;
        bus.alu_srcA   = 1'b0;
        bus.alu_srcB   = 2'b00;
        bus.pcSource   = 3'd0;
        bus.rf_wr_sel  = 2'd0;
        bus.illegal_op = 1'b0;

        case (state)
            ST_INIT: next_state = ST_FETCH;

            ST_FETCH: begin
                bus.memRDEN1 = 1'b1;
                next_state   = ST_EXEC;
            end

            ST_EXEC: begin
                bus.pcWrite = 1'b1;
                next_state  = ST_FETCH;
                case (opcode)
                    OPC_OP: begin
                        bus.alu_fun   = {bus.ir[30], funct3};
                        bus.regWrite  = 1'b1;
                        bus.rf_wr_sel = 2'd3;
                    end
                    OPC_OP_IMM: begin
                        // Only the right shifts use bit 30 as an opcode bit; elsewhere it is immediate data.
                        bus.alu_fun   = (funct3 == 3'b101) ? {bus.ir[30], funct3} : {1'b0, funct3};
                        bus.alu_srcB  = 2'b01;
                        bus.regWrite  = 1'b1;
                        bus.rf_wr_sel = 2'd3;
                    end
                    OPC_LUI: begin
                        bus.alu_fun   = 4'b1001;
                        bus.alu_srcA  = 1'b1;
                        bus.regWrite  = 1'b1;
                        bus.rf_wr_sel = 2'd3;
                    end
                    OPC_AUIPC: begin
                        bus.alu_srcA  = 1'b1;
                        bus.alu_srcB  = 2'b11;
                        bus.regWrite  = 1'b1;
                        bus.rf_wr_sel = 2'd3;
                    end
                    OPC_JAL: begin
                        bus.pcSource = 3'd3;
                        bus.regWrite = 1'b1;
                    end
                    OPC_JALR: begin
                        bus.pcSource = 3'd1;
                        bus.regWrite = 1'b1;
                    end
                    OPC_BRANCH: bus.pcSource = br_taken ? 3'd2 : 3'd0;
                    OPC_STORE: begin
                        bus.alu_srcB = 2'b10;
                        bus.memWE2   = 1'b1;
                    end
                    OPC_LOAD: begin
                        bus.alu_srcB = 2'b01;
                        bus.memRDEN2 = 1'b1;
                        bus.pcWrite  = 1'b0;
                        next_state   = ST_WRITEBACK;
                    end
                    default: bus.illegal_op = 1'b1;
                endcase
            end

            ST_WRITEBACK: begin
                // Keep the load address on the ALU while the data word is written back.
                bus.alu_srcB  = 2'b01;
                bus.regWrite  = 1'b1;
                bus.rf_wr_sel = 2'd2;
                bus.pcWrite   = 1'b1;
                next_state    = ST_FETCH;
            end
        endcase
    end
endmodule

// File: tb/tb_otter_cu_fsm_dcdr.sv
// Bench for otter_cu_fsm_dcdr: directed instruction walk plus randomized instructions and
// operands, checked against an instruction-level reference model of the control outputs.
module tb_otter_cu_fsm_dcdr;
    typedef struct packed {
        logic       pc_write;
        logic       reg_write;
        logic       mem_we2;
        logic       mem_rden1;
        logic       mem_rden2;
        logic [3:0] alu_fun;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] pc_source;
        logic [1:0] rf_wr_sel;
        logic       illegal_op;
    } ctrl_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    otter_cu_fsm_dcdr_if bus ();

    otter_cu_fsm_dcdr dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic ctrl_t observe();
        ctrl_t o;
        o.pc_write   = bus.pcWrite;
        o.reg_write  = bus.regWrite;
        o.mem_we2    = bus.memWE2;
        o.mem_rden1  = bus.memRDEN1;
        o.mem_rden2  = bus.memRDEN2;
        o.alu_fun    = bus.alu_fun;
        o.alu_src_a  = bus.alu_srcA;
        o.alu_src_b  = bus.alu_srcB;
        o.pc_source  = bus.pcSource;
        o.rf_wr_sel  = bus.rf_wr_sel;
        o.illegal_op = bus.illegal_op;
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: what the control word should be in each phase of an instruction,
    // derived from the instruction's meaning and the actual operand values.
    function automatic ctrl_t fetch_model();
        ctrl_t e = '0;
        e.mem_rden1 = 1'b1;
        return e;
    endfunction

    function automatic ctrl_t exec_model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        ctrl_t      e = '0;
        logic [2:0] f3 = i[14:12];
        logic       cond;
        logic       has_cond;
        e.pc_write = 1'b1;
        case (i[6:0])
            7'h33: begin e.alu_fun = {i[30], f3}; e.reg_write = 1; e.rf_wr_sel = 3; end
            7'h13: begin e.alu_fun = {i[30] & (f3 == 3'b101), f3}; e.alu_src_b = 1; e.reg_write = 1; e.rf_wr_sel = 3; end
            7'h37: begin e.alu_fun = 4'b1001; e.alu_src_a = 1; e.reg_write = 1; e.rf_wr_sel = 3; end
            7'h17: begin e.alu_src_a = 1; e.alu_src_b = 3; e.reg_write = 1; e.rf_wr_sel = 3; end
            7'h6F: begin e.pc_source = 3; e.reg_write = 1; end
            7'h67: begin e.pc_source = 1; e.reg_write = 1; end
            7'h63: begin
                // f3[2:1] picks the relation, f3[0] negates it; 01x has no relation.
                has_cond = (f3[2:1] != 2'b01);
                cond = (f3[2:1] == 2'b00) ? (a == b) :
                       (f3[2:1] == 2'b10) ? ($signed(a) < $signed(b)) : (a < b);
                e.pc_source = (has_cond && (cond ^ f3[0])) ? 3'd2 : 3'd0;
            end
            7'h23: begin e.alu_src_b = 2; e.mem_we2 = 1; end
            7'h03: begin e.alu_src_b = 1; e.mem_rden2 = 1; e.pc_write = 0; end
            default: e.illegal_op = 1;
        endcase
        return e;
    endfunction

    function automatic ctrl_t wb_model(input ctrl_t ex);
        ctrl_t e = '0;
        e.alu_fun   = ex.alu_fun;
        e.alu_src_a = ex.alu_src_a;
        e.alu_src_b = ex.alu_src_b;
        e.reg_write = 1'b1;
        e.rf_wr_sel = 2'd2;
        e.pc_write  = 1'b1;
        return e;
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        bus.ir     = i;
        bus.br_eq  = (a == b);
        bus.br_lt  = ($signed(a) < $signed(b));
        bus.br_ltu = (a < b);
    endtask

    // Expects to start in FETCH, sampled just after a clock edge.
    task automatic run_instr(input string name, input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
        ctrl_t ex;
        drive(i, a, b);
        check($sformatf("%s fetch ir=%h", name, i), 32'(observe()), 32'(fetch_model()));
        tick();
        ex = exec_model(i, a, b);
        check($sformatf("%s exec ir=%h", name, i), 32'(observe()), 32'(ex));
        tick();
        if (ex.mem_rden2) begin
            check($sformatf("%s writeback ir=%h", name, i), 32'(observe()), 32'(wb_model(ex)));
            tick();
        end
    endtask

    logic [31:0] legal_ops [9] = '{32'h33, 32'h13, 32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h23, 32'h03};

    initial begin
        drive($urandom, 0, 0);
        #1 RST = 1'b1;
        #1 check("reset async", 32'(observe()), 32'h0);
        tick();
        drive($urandom, 0, 1);
        check("reset held", 32'(observe()), 32'h0);
        tick();
        RST = 1'b0;
        #1 check("init after release", 32'(observe()), 32'h0);
        tick();

        run_instr("add",   32'h002081B3, 32'd1, 32'd2);
        run_instr("sra",   32'h4020D1B3, 32'd9, 32'd3);
        run_instr("auipc", 32'h00000197, 32'd0, 32'd0);
        run_instr("lw",    32'h0000A183, 32'd4, 32'd8);
        run_instr("beq_t", 32'h00208463, 32'd5, 32'd5);
        run_instr("beq_n", 32'h00208463, 32'd1, 32'd2);
        run_instr("bgeu",  32'h0020F463, 32'd7, 32'd3);
        run_instr("srai",  32'h4030D093, 32'd0, 32'd0);
        run_instr("lui",   32'h123450B7, 32'd0, 32'd0);
        run_instr("jal",   32'h008000EF, 32'd0, 32'd0);
        run_instr("illeg", 32'hFFFFFFFF, 32'd3, 32'd3);

        // Reset in the middle of a store's EXEC cycle, away from any clock edge.
        drive(32'h0020A023, 32'd1, 32'd2);
        check("sw fetch", 32'(observe()), 32'(fetch_model()));
        tick();
        check("sw exec", 32'(observe()), 32'(exec_model(32'h0020A023, 32'd1, 32'd2)));
        #2 RST = 1'b1;
        #1 check("sw reset no edge", 32'(observe()), 32'h0);
        RST = 1'b0;
        tick();
        run_instr("after_reset", 32'h002081B3, 32'd0, 32'd0);

        for (int n = 0; n < 150; n++) begin
            logic [31:0] i = $urandom;
            logic [31:0] a = $urandom;
            logic [31:0] b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            int          k = $urandom_range(0, 9);
            if (k < 9) i = {i[31:7], legal_ops[k][6:0]};
            run_instr($sformatf("rand%0d", n), i, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/otter_cu_fsm_dcdr.md
Name: otter_cu_fsm_dcdr

Overview:
- Multicycle control unit for the OTTER RV32I core: a fetch/execute state machine plus an instruction decoder.
- It is the producer side of the ALU operand-mux interface. It generates alu_fun, alu_srcA and alu_srcB with the exact encodings the ALU datapath consumes.
- It also drives the PC, register-file and memory enables.
- It sits between the instruction register / branch comparator and the datapath.

Parameters:
- none (RV32I base set; encodings fixed by the datapath)

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- ir  in  32  current instruction (memory DOUT1), valid in EXEC and WRITEBACK
- br_eq  in  1  rs1 == rs2
- br_lt  in  1  signed rs1 < rs2
- br_ltu  in  1  unsigned rs1 < rs2
- pcWrite  out  1  PC register load enable
- regWrite  out  1  register-file write enable
- memWE2  out  1  data-memory write enable
- memRDEN1  out  1  instruction-memory read enable
- memRDEN2  out  1  data-memory read enable
- alu_fun  out  4  ALU op: add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, sub 1000, lui-copy 1001, sra 1101
- alu_srcA  out  1  0=RS1, 1=U_type
- alu_srcB  out  2  00=RS2, 01=I_type, 10=S_type, 11=PC_OUT
- pcSource  out  3  0=PC+4, 1=JALR, 2=branch, 3=JAL
- rf_wr_sel  out  2  0=PC+4, 2=data-mem DOUT2, 3=ALU_RESULT
- illegal_op  out  1  one-cycle pulse in EXEC for an unrecognised opcode

Behaviour:
- States: INIT, FETCH, EXEC, WRITEBACK. The state register is the only sequential element. Outputs are combinational from the state and ir.
- Reset:
  - RST high forces INIT immediately, independent of CLK.
  - All outputs are 0 while in INIT.
  - Reset mid-instruction aborts the instruction; no enable stays high once RST asserts.
- INIT→FETCH unconditionally on the first clock after RST deasserts.
- FETCH: memRDEN1=1, all other enables 0. FETCH→EXEC.
- EXEC decodes ir[6:0]. Any unused mux select defaults to 0. Per opcode:
  - OP 0110011: alu_fun={ir[30],funct3}, srcA=0, srcB=00, regWrite=1, rf_wr_sel=3.
  - OP_IMM 0010011: alu_fun={ir[30],funct3} when funct3=101, else {0,funct3}. srcB=01, regWrite=1, rf_wr_sel=3.
  - LUI 0110111: alu_fun=1001, srcA=1, regWrite=1, rf_wr_sel=3.
  - AUIPC 0010111: alu_fun=0000, srcA=1, srcB=11, regWrite=1, rf_wr_sel=3.
  - JAL 1101111: pcSource=3, regWrite=1, rf_wr_sel=0.
  - JALR 1100111: pcSource=1, regWrite=1, rf_wr_sel=0.
  - BRANCH 1100011: no register write. Branch is taken per funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu. Taken→pcSource=2, else 0. funct3 010/011 → not taken.
  - STORE 0100011: alu_fun=0000, srcB=10, memWE2=1.
  - LOAD 0000011: alu_fun=0000, srcB=01, memRDEN2=1, pcWrite=0. EXEC→WRITEBACK.
  - Unknown opcode: treated as NOP (pcWrite=1, pcSource=0, no writes), illegal_op=1.
- pcWrite=1 in EXEC for every opcode except LOAD. Non-load instructions go EXEC→FETCH.
- WRITEBACK (loads only):
  - alu_fun/srcA/srcB held as in EXEC so the address stays stable.
  - memRDEN2=0 in WRITEBACK.
  - regWrite=1, rf_wr_sel=2, pcWrite=1, pcSource=0.
  - WRITEBACK→FETCH.
- Latency: non-load instructions take 2 cycles (FETCH+EXEC); loads take 3 cycles.
- regWrite and memWE2 are never both 1. memWE2 and memRDEN2 are never both 1.

Test Plan:
- Reset → state INIT with all outputs 0. Deassert RST → next edge memRDEN1=1 (FETCH).
- ir=0x002081B3 (add x3,x1,x2) in EXEC → alu_fun=0000, srcA=0, srcB=00, regWrite=1, rf_wr_sel=3, pcWrite=1; next state FETCH.
- ir=0x4020D1B3 (sra) → alu_fun=1101. ir=0x00000197 (auipc) → srcA=1, srcB=11, alu_fun=0000.
- ir=0x0000A183 (lw) → EXEC: memRDEN2=1, srcB=01, pcWrite=0. WRITEBACK: regWrite=1, rf_wr_sel=2, pcWrite=1. Then FETCH.
- ir=0x00208463 (beq):
  - br_eq=1 → pcSource=2.
  - br_eq=0 → pcSource=0.
  - Repeat bgeu (funct3 111) with br_ltu=0 → pcSource=2.
- ir=0xFFFFFFFF → illegal_op=1 for one cycle, pcWrite=1, regWrite=0, memWE2=0. Assert RST mid-EXEC of an sw → memWE2 drops to 0 with no clock edge.
